fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (IEEE-754 single).
REQ-002 Parameter DIV_LATENCY, default 4, clock cycles from stable divider operands to valid divider result (legal 1..15).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  XLEN  dividend.
REQ-008 in_b  input  XLEN  divisor.
REQ-009 div_a  output  XLEN  dividend to the downstream divider.
REQ-010 div_b  output  XLEN  divisor to the downstream divider.
REQ-011 div_result  input  XLEN  quotient returned by the divider.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_result  output  XLEN  final quotient.
REQ-015 out_overflow, out_underflow, out_exception  output  1 each  status flags, qualified by out_valid.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, in_valid=1 SHALL register in_a/in_b, classify them, and transition to WAIT (normal) or DONE (special case) on the same edge.
REQ-018 div_a/div_b SHALL be driven from the operand registers and held constant throughout WAIT.
REQ-019 On entering WAIT, a 4-bit counter SHALL load DIV_LATENCY-1 and decrement once per cycle.
REQ-020 In WAIT with counter=0, the block SHALL register div_result into out_result and go to DONE; out_valid SHALL rise DIV_LATENCY+1 cycles after the accept edge.
REQ-021 Special cases SHALL bypass the divider, with out_valid rising 1 cycle after accept, in priority order:
  - either operand NaN, 0/0, or inf/inf -> 0x7FC00000, exception=1;
  - B zero with A finite nonzero -> signed inf, exception=1;
  - A inf -> signed inf;
  - B inf or A zero -> signed zero.
REQ-022 The sign of every non-NaN result SHALL be in_a[31] XOR in_b[31].
REQ-023 On the normal path, overflow SHALL be 1 iff result exponent=8'hFF; underflow SHALL be 1 iff result exponent=8'h00 and A nonzero.
REQ-024 In DONE, out_valid, out_result and all flags SHALL hold stable until out_ready=1; out_valid & out_ready SHALL return the FSM to IDLE.
REQ-025 A new operand SHALL NOT be accepted on the same edge as the result handshake; in_ready rises the cycle after.
REQ-026 in_valid SHALL be ignored outside IDLE; no operand is queued.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0, out_valid=0, out_result=0, all flags=0, div_a=div_b=0, in_ready=1 from the next cycle.
REQ-028 rst asserted in WAIT or DONE SHALL abort the operation; its result SHALL never appear on out_valid.

Configuration
REQ-029 With FP_DIV_SEQ_DENORM_FLUSH_EN defined, any subnormal operand SHALL be treated as signed zero before classification, and the zero-case rules apply.
REQ-030 Without FP_DIV_SEQ_DENORM_FLUSH_EN, subnormal operands SHALL take the normal divider path unchanged.

Verification
REQ-031 A=0x40C00000, B=0x40000000, divider model returning 0x40400000 -> out_result=0x40400000, flags 0, out_valid at accept+5 (DIV_LATENCY=4).
REQ-032 A=0x3F800000, B=0x00000000 -> out_result=0x7F800000, exception=1, out_valid at accept+1.
REQ-033 A=0x00000000, B=0x80000000 -> 0x7FC00000, exception=1; A=0xFF800000, B=0x40000000 -> 0xFF800000, exception=0.
REQ-034 out_ready held 0 for 6 cycles in DONE -> out_valid and out_result stable; in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-035 rst pulsed in the 2nd WAIT cycle -> out_valid never rises for that operation; next operation 6.0/2.0 completes correctly.
REQ-036 A=0x00000001, B=0x3F800000 -> with macro: 0x00000000 at accept+1; without macro: divider path, out_valid at accept+5.

Source files
------------

// File: rtl/fp_div_seq.sv
// IEEE-754 single divide sequencer wrapping an external fixed-latency divider.
// Special operands (NaN, inf, zero) are resolved locally and never reach the divider.
// Latency: DIV_LATENCY+1 cycles from accept on the divider path, 1 cycle for special operands.
// Backpressure: one operation in flight; in_ready only when idle; the result is held until out_ready.
// FP_DIV_SEQ_DENORM_FLUSH_EN: when defined, subnormal operands are classified as signed zero.
module fp_div_seq #(
    parameter int XLEN        = 32,
    parameter int DIV_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic [XLEN-1:0] div_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_overflow,
    output logic            out_underflow,
    output logic            out_exception
);
    localparam int EW = 8;
    localparam int MW = XLEN - 1 - EW;
    localparam logic [3:0]      CNT_LOAD = 4'(DIV_LATENCY - 1);
    localparam logic [XLEN-1:0] QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            exc_q, exc_d;

    logic [EW-1:0]   a_exp, b_exp, r_exp;
    logic            a_man_nz, b_man_nz;
    logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic            res_sign, special, spec_exc;
    logic [XLEN-1:0] spec_res;

    // Operand classification on the incoming pair, used only on the accept edge.
    always_comb begin
        a_exp    = in_a[XLEN-2 -: EW];
        b_exp    = in_b[XLEN-2 -: EW];
        a_man_nz = |in_a[MW-1:0];
        b_man_nz = |in_b[MW-1:0];
        a_nan    = (&a_exp) & a_man_nz;
        b_nan    = (&b_exp) & b_man_nz;
        a_inf    = (&a_exp) & ~a_man_nz;
        b_inf    = (&b_exp) & ~b_man_nz;
`ifdef FP_DIV_SEQ_DENORM_FLUSH_EN
        a_zero   = ~|a_exp;
        b_zero   = ~|b_exp;
`else
        a_zero   = (~|a_exp) & ~a_man_nz;
        b_zero   = (~|b_exp) & ~b_man_nz;
`endif
        res_sign = in_a[XLEN-1] ^ in_b[XLEN-1];

        special  = 1'b1;
        spec_exc = 1'b0;
        spec_res = {res_sign, {(XLEN-1){1'b0}}};
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_res = QNAN;
            spec_exc = 1'b1;
        end else if (b_zero & ~a_zero & ~a_inf) begin
            spec_res = {res_sign, {EW{1'b1}}, {MW{1'b0}}};
            spec_exc = 1'b1;
        end else if (a_inf) begin
            spec_res = {res_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else if (b_inf | a_zero) begin
            spec_res = {res_sign, {(XLEN-1){1'b0}}};
        end else begin
            special  = 1'b0;
        end
    end

    assign r_exp = div_result[XLEN-2 -: EW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        exc_d   = exc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (special) begin
                        res_d   = spec_res;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        exc_d   = spec_exc;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d   = div_result;
                    ovf_d   = &r_exp;
                    unf_d   = (~|r_exp) & (|a_q[XLEN-2:0]);
                    exc_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Only returning to IDLE here keeps a new accept off the handshake edge.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            exc_q   <= exc_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign out_result    = res_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_exception = exc_q;
endmodule
